// File: rtl/render_pkg.sv
// rtl/render_pkg.sv - shared render-area constants, sequencer state type and colour quantiser
package render_pkg;

    // Render area, shared with the framebuffer writer.
    localparam int RENDER_WIDTH  = 512;
    localparam int RENDER_HEIGHT = 384;

    localparam int X_W   = 11;
    localparam int Y_W   = 10;
    localparam int TAG_W = X_W + Y_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    // Round an 8-bit channel to 4 bits: min((c + 8) >> 4, 15).
    // The 9-bit sum only overflows into bit 8 for c >= 0xF8, which saturates.
    function automatic logic [3:0] quantise_channel(input logic [7:0] c);
        logic [8:0] w_sum;
        w_sum = {1'b0, c} + 9'd8;
        quantise_channel = w_sum[8] ? 4'hF : w_sum[7:4];
    endfunction

endpackage

// File: rtl/coord_tag_fifo.sv
// rtl/coord_tag_fifo.sv - in-order tag FIFO holding request coordinates
// Ports: clk_in/rst_in clock and async active-high reset; push_in/push_data_in write;
// pop_in/pop_data_out read (data valid while not empty); full_out, empty_out, count_out status.
// Push and pop in the same cycle are both honoured; status is registered-count based.
module coord_tag_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 21
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       push_in,
    input  logic [DATA_W-1:0]          push_data_in,
    input  logic                       pop_in,
    output logic [DATA_W-1:0]          pop_data_out,
    output logic                       full_out,
    output logic                       empty_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full_out     = (r_count == CNT_W'(DEPTH));
    assign empty_out    = (r_count == '0);
    assign count_out    = r_count;
    assign pop_data_out = r_mem[r_rd_ptr];

    // Overflow/underflow requests are dropped so the pointers never corrupt.
    assign w_do_push = push_in && !full_out;
    assign w_do_pop  = pop_in && !empty_out;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk_in) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data_in;
    end

endmodule

// File: rtl/render_pixel_sequencer.sv
// rtl/render_pixel_sequencer.sv - raster sweep of shade requests, tagged return path to framebuffer writer
// Ports: clk_in/rst_in clock and async active-high reset; frame_start_in sweep request;
// req_valid_out/req_ready_in/req_x_out/req_y_out shader request; res_valid_in/res_hit_in/res_*_in
// shader result; x_out/y_out/r_out/g_out/b_out/visible_out/valid_out writer pixel;
// busy_out, frame_done_out, orphan_err_out status.
module render_pixel_sequencer
    import render_pkg::*;
#(
    parameter int WIDTH      = RENDER_WIDTH,
    parameter int HEIGHT     = RENDER_HEIGHT,
    parameter int FIFO_DEPTH = 16
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           frame_start_in,
    input  logic           req_ready_in,
    output logic           req_valid_out,
    output logic [X_W-1:0] req_x_out,
    output logic [Y_W-1:0] req_y_out,
    input  logic           res_valid_in,
    input  logic           res_hit_in,
    input  logic [7:0]     res_r_in,
    input  logic [7:0]     res_g_in,
    input  logic [7:0]     res_b_in,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic [3:0]     r_out,
    output logic [3:0]     g_out,
    output logic [3:0]     b_out,
    output logic           visible_out,
    output logic           valid_out,
    output logic           busy_out,
    output logic           frame_done_out,
    output logic           orphan_err_out
);

    localparam int             CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [X_W-1:0] LAST_X = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] LAST_Y = Y_W'(HEIGHT - 1);

    seq_state_t r_state;
    seq_state_t w_next_state;

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;

    logic [X_W-1:0] r_x_out;
    logic [Y_W-1:0] r_y_out;
    logic [3:0]     r_r_out;
    logic [3:0]     r_g_out;
    logic [3:0]     r_b_out;
    logic           r_visible;
    logic           r_valid;
    logic           r_frame_done;
    logic           r_orphan;

    logic             w_hs;
    logic             w_pop;
    logic             w_orphan;
    logic             w_last_coord;
    logic             w_last_pop;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic [TAG_W-1:0] w_tag;
    logic [3:0]       w_r_q;
    logic [3:0]       w_g_q;
    logic [3:0]       w_b_q;

    coord_tag_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (TAG_W)
    ) u_tag_fifo (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .push_in      (w_hs),
        .push_data_in ({r_x, r_y}),
        .pop_in       (w_pop),
        .pop_data_out (w_tag),
        .full_out     (w_full),
        .empty_out    (w_empty),
        .count_out    (w_count)
    );

    assign w_hs         = req_valid_out && req_ready_in;
    assign w_pop        = res_valid_in && !w_empty;
    assign w_orphan     = res_valid_in && w_empty;
    assign w_last_coord = (r_x == LAST_X) && (r_y == LAST_Y);
    // Nothing is pushed in DRAIN, so popping the sole remaining tag yields the frame's last pixel.
    assign w_last_pop   = (r_state == DRAIN) && w_pop && (w_count == CNT_W'(1));

    assign w_r_q = res_hit_in ? quantise_channel(res_r_in) : 4'd0;
    assign w_g_q = res_hit_in ? quantise_channel(res_g_in) : 4'd0;
    assign w_b_q = res_hit_in ? quantise_channel(res_b_in) : 4'd0;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // DRAIN leaves on the cycle frame_done_out is high, so busy_out drops one cycle after it.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (frame_start_in)          w_next_state = SWEEP;
            SWEEP:   if (w_hs && w_last_coord)    w_next_state = DRAIN;
            DRAIN:   if (r_frame_done)            w_next_state = IDLE;
            default:                              w_next_state = IDLE;
        endcase
    end

    // Full is from the registered count, so a pop frees its slot only on the following cycle.
    always_comb begin
        req_valid_out = (r_state == SWEEP) && !w_full;
        busy_out      = (r_state != IDLE);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_hs) begin
            if (r_x == LAST_X) begin
                r_x <= '0;
                r_y <= (r_y == LAST_Y) ? '0 : r_y + Y_W'(1);
            end else begin
                r_x <= r_x + X_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_x_out      <= '0;
            r_y_out      <= '0;
            r_r_out      <= '0;
            r_g_out      <= '0;
            r_b_out      <= '0;
            r_visible    <= 1'b0;
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
            r_orphan     <= 1'b0;
        end else begin
            r_valid      <= w_pop;
            r_frame_done <= w_last_pop;
            if (w_pop) begin
                r_x_out   <= w_tag[TAG_W-1:Y_W];
                r_y_out   <= w_tag[Y_W-1:0];
                r_visible <= res_hit_in;
                r_r_out   <= w_r_q;
                r_g_out   <= w_g_q;
                r_b_out   <= w_b_q;
            end
            if (w_orphan) r_orphan <= 1'b1;
        end
    end

    assign req_x_out      = r_x;
    assign req_y_out      = r_y;
    assign x_out          = r_x_out;
    assign y_out          = r_y_out;
    assign r_out          = r_r_out;
    assign g_out          = r_g_out;
    assign b_out          = r_b_out;
    assign visible_out    = r_visible;
    assign valid_out      = r_valid;
    assign frame_done_out = r_frame_done;
    assign orphan_err_out = r_orphan;

endmodule

// File: tb/tb_render_pixel_sequencer.sv
// tb/tb_render_pixel_sequencer.sv - scoreboard bench for render_pixel_sequencer
module tb_render_pixel_sequencer;

    localparam int W = 4;
    localparam int H = 2;
    localparam int N = W * H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (4x2)
    logic        rst, frame_start, req_ready, req_valid;
    logic [10:0] req_x;
    logic [9:0]  req_y;
    logic        res_valid, res_hit;
    logic [7:0]  res_r, res_g, res_b;
    logic [10:0] x_o;
    logic [9:0]  y_o;
    logic [3:0]  r_o, g_o, b_o;
    logic        vis, valid, busy, done, orphan;

    // Second DUT (8x4) used for the outstanding-limit test
    logic        b_rst, b_frame_start, b_ready, b_req_valid;
    logic [10:0] b_req_x;
    logic [9:0]  b_req_y;
    logic        b_res_valid, b_res_hit;
    logic [7:0]  b_res_r, b_res_g, b_res_b;
    logic [10:0] b_x_o;
    logic [9:0]  b_y_o;
    logic [3:0]  b_r_o, b_g_o, b_b_o;
    logic        b_vis, b_valid, b_busy, b_done, b_orphan;

    render_pixel_sequencer #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(16)) dut (
        .clk_in(clk), .rst_in(rst), .frame_start_in(frame_start), .req_ready_in(req_ready),
        .req_valid_out(req_valid), .req_x_out(req_x), .req_y_out(req_y),
        .res_valid_in(res_valid), .res_hit_in(res_hit),
        .res_r_in(res_r), .res_g_in(res_g), .res_b_in(res_b),
        .x_out(x_o), .y_out(y_o), .r_out(r_o), .g_out(g_o), .b_out(b_o),
        .visible_out(vis), .valid_out(valid), .busy_out(busy),
        .frame_done_out(done), .orphan_err_out(orphan)
    );

    render_pixel_sequencer #(.WIDTH(8), .HEIGHT(4), .FIFO_DEPTH(16)) dut_b (
        .clk_in(clk), .rst_in(b_rst), .frame_start_in(b_frame_start), .req_ready_in(b_ready),
        .req_valid_out(b_req_valid), .req_x_out(b_req_x), .req_y_out(b_req_y),
        .res_valid_in(b_res_valid), .res_hit_in(b_res_hit),
        .res_r_in(b_res_r), .res_g_in(b_res_g), .res_b_in(b_res_b),
        .x_out(b_x_o), .y_out(b_y_o), .r_out(b_r_o), .g_out(b_g_o), .b_out(b_b_o),
        .visible_out(b_vis), .valid_out(b_valid), .busy_out(b_busy),
        .frame_done_out(b_done), .orphan_err_out(b_orphan)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Shader colour table with hand-quantised expectations.
    logic [7:0] tbl_r   [4] = '{8'h07, 8'h07, 8'hF7, 8'h18};
    logic [7:0] tbl_g   [4] = '{8'h08, 8'h08, 8'h10, 8'h80};
    logic [7:0] tbl_b   [4] = '{8'hFF, 8'hFF, 8'h17, 8'hF8};
    bit         tbl_hit [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] tbl_qr  [4] = '{4'd0, 4'd0, 4'd15, 4'd2};
    logic [3:0] tbl_qg  [4] = '{4'd1, 4'd0, 4'd1,  4'd8};
    logic [3:0] tbl_qb  [4] = '{4'd15, 4'd0, 4'd1, 4'd15};
    bit         pat     [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    logic [34:0] exp_q [$];
    int          pend_due [$];
    int          cyc = 0;
    int          req_idx = 0;
    int          ret_idx = 0;
    bit          ret_en = 1'b0;
    int          orphan_req = 0;
    int          orphan_done = 0;
    int          n_out = 0;
    int          b_hs = 0;

    // Shader model: returns results in order 3 cycles after accept; checks request order and hold.
    initial begin
        int k;
        logic        prev_stall;
        logic [10:0] prev_x;
        logic [9:0]  prev_y;
        prev_stall = 1'b0;
        prev_x = '0;
        prev_y = '0;
        res_valid = 1'b0; res_hit = 1'b0; res_r = '0; res_g = '0; res_b = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (orphan_req != orphan_done) begin
                orphan_done++;
                res_valid = 1'b1; res_hit = 1'b1;
                res_r = tbl_r[0]; res_g = tbl_g[0]; res_b = tbl_b[0];
            end else if (ret_en && pend_due.size() > 0 && pend_due[0] <= cyc) begin
                k = ret_idx % 4;
                void'(pend_due.pop_front());
                res_valid = 1'b1; res_hit = tbl_hit[k];
                res_r = tbl_r[k]; res_g = tbl_g[k]; res_b = tbl_b[k];
                exp_q.push_back({11'(ret_idx % W), 10'(ret_idx / W), tbl_qr[k], tbl_qg[k],
                                 tbl_qb[k], tbl_hit[k], (ret_idx == N - 1)});
                ret_idx++;
            end else begin
                res_valid = 1'b0;
            end
            @(negedge clk);
            if (rst) begin
                pend_due.delete();
                prev_stall = 1'b0;
            end else begin
                if (frame_start && !busy) begin
                    req_idx = 0;
                    ret_idx = 0;
                end
                if (prev_stall && req_valid)
                    check("req_hold", {req_x, req_y}, {prev_x, prev_y});
                if (req_valid && req_ready) begin
                    check("req_coord", {req_x, req_y}, {11'(req_idx % W), 10'(req_idx / W)});
                    req_idx++;
                    pend_due.push_back(cyc + 3);
                end
                prev_stall = req_valid && !req_ready;
                prev_x = req_x;
                prev_y = req_y;
            end
        end
    end

    // Output monitor: every valid pixel must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (valid) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pixel: got x=%0d y=%0d, required no pixel", x_o, y_o);
                end else begin
                    check("pixel", {x_o, y_o, r_o, g_o, b_o, vis, done}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (b_req_valid && b_ready) b_hs++;
        end
    end

    task automatic run_frame(input string name, input bit toggle);
        bit got;
        int n_before;
        got = 1'b0;
        n_before = n_out;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (toggle) req_ready = pat[i % 4];
            frame_start = toggle && (i == 5);
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        frame_start = 1'b0;
        check({name, "_done_seen"}, 64'(got), 64'd1);
        check({name, "_busy_at_done"}, 64'(busy), 64'd1);
        @(negedge clk);
        check({name, "_busy_after"}, 64'(busy), 64'd0);
        check({name, "_pixel_count"}, 64'(n_out - n_before), 64'(N));
        check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
        req_ready = 1'b1;
    endtask

    initial begin
        bit found;
        rst = 1'b0; frame_start = 1'b0; req_ready = 1'b0;
        b_rst = 1'b0; b_frame_start = 1'b0; b_ready = 1'b1; b_res_valid = 1'b0;
        b_res_hit = 1'b0; b_res_r = '0; b_res_g = '0; b_res_b = '0;
        #2;
        rst = 1'b1;
        b_rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req", {req_valid, req_x, req_y}, 64'd0);
        check("rst_pix", {valid, x_o, y_o, r_o, g_o, b_o, vis}, 64'd0);
        check("rst_flags", {busy, done, orphan}, 64'd0);
        tick();
        rst = 1'b0;
        b_rst = 1'b0;
        tick();

        // Frame 1: ready always high, fixed shader latency.
        req_ready = 1'b1;
        ret_en = 1'b1;
        run_frame("frame1", 1'b0);
        repeat (3) tick();

        // Frame 2: ready pattern 1,0,0,1 and a stray frame_start mid-sweep.
        run_frame("frame2", 1'b1);
        repeat (4) tick();
        check("idle_after_stray_start", {busy, req_valid}, 64'd0);

        // Orphan result in IDLE.
        ret_en = 1'b0;
        orphan_req++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("orphan_no_valid", 64'(valid), 64'd0);
        end
        check("orphan_set", 64'(orphan), 64'd1);
        repeat (5) tick();
        check("orphan_sticky", 64'(orphan), 64'd1);

        // Outstanding limit on the larger DUT: no results returned.
        b_frame_start = 1'b1;
        tick();
        b_frame_start = 1'b0;
        repeat (40) tick();
        check("limit_count", 64'(b_hs), 64'd16);
        check("limit_stalled", {b_req_valid, b_busy}, 64'b01);
        b_res_valid = 1'b1;
        tick();
        b_res_valid = 1'b0;
        repeat (10) tick();
        check("limit_one_more", 64'(b_hs), 64'd17);
        check("limit_stalled_again", 64'(b_req_valid), 64'd0);
        check("limit_no_orphan", 64'(b_orphan), 64'd0);

        // Reset in the middle of a sweep at (2,1), then restart.
        req_ready = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_valid && req_x == 11'd2 && req_y == 10'd1) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_2_1", 64'(found), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("midrst_req", {req_valid, req_x, req_y}, 64'd0);
        check("midrst_pix", {valid, x_o, y_o, r_o, g_o, b_o, vis}, 64'd0);
        check("midrst_flags", {busy, done, orphan}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        @(negedge clk);
        check("restart_origin", {req_valid, req_x, req_y}, {1'b1, 11'd0, 10'd0});
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/render_pixel_sequencer.md
Name: render_pixel_sequencer

Overview:
- Sweeps the WIDTH x HEIGHT render area once per frame and issues one pixel-shade request per coordinate to the block shader.
- Tags each in-flight request with its (x,y) in a small in-order FIFO and re-attaches the coordinate when the shader result returns.
- Quantises the result colour to 4 bits per channel and drives the framebuffer-writer stage (x_in_block, y_in_block, r/g/b_in_formatted, block_visible, valid_in).

Parameters:
WIDTH, 512, render columns
HEIGHT, 384, render rows
FIFO_DEPTH, 16, maximum outstanding shader requests (power of two)

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-high
frame_start_in  input  1  one-cycle pulse requesting a new sweep
req_ready_in  input  1  shader accepts a request this cycle
req_valid_out  output  1  request valid
req_x_out  output  11  request column
req_y_out  output  10  request row
res_valid_in  input  1  shader result valid (in order, one per accepted request)
res_hit_in  input  1  pixel hits a block
res_r_in, res_g_in, res_b_in  input  8 each  result colour
x_out  output  11  pixel column to writer
y_out  output  10  pixel row to writer
r_out, g_out, b_out  output  4 each  formatted colour
visible_out  output  1  hit flag
valid_out  output  1  output pixel valid
busy_out  output  1  sweep or drain in progress
frame_done_out  output  1  one-cycle pulse after last pixel emitted
orphan_err_out  output  1  sticky: result arrived with empty tag FIFO

Behaviour:
- Reset (async assert, sync release): state IDLE; x/y counters 0; FIFO empty, outstanding 0; all outputs 0, including orphan_err_out.
- States:
  - IDLE: frame_start_in moves to SWEEP.
  - SWEEP: issue requests; after the handshake at (WIDTH-1, HEIGHT-1), go to DRAIN.
  - DRAIN: wait for FIFO empty; on the cycle the last output pixel is driven, go to IDLE and pulse frame_done_out with valid_out.
  - frame_start_in in SWEEP or DRAIN is ignored (not queued).
- Issue rule:
  - req_valid_out = (state==SWEEP) && (outstanding < FIFO_DEPTH). It is combinational from registered state.
  - Handshake is req_valid_out && req_ready_in. On a handshake: push {req_x,req_y} into the FIFO, then advance x.
  - x wraps WIDTH-1 -> 0 and increments y. y never exceeds HEIGHT-1.
  - req_x/req_y hold steady while req_valid_out is high and req_ready_in is low.
- Return rule:
  - On res_valid_in with FIFO non-empty: pop, and register outputs next cycle (latency 1).
    - x_out/y_out = popped coordinate; visible_out = res_hit_in; valid_out = 1.
    - Colour: each channel c -> min((c+8)>>4, 15), computed in 9 bits. Example: 0x07 -> 0, 0x08 -> 1, 0xF7 -> 15, 0xFF -> 15.
    - When res_hit_in = 0, r/g/b_out = 0.
  - On res_valid_in with FIFO empty: drop the result, set orphan_err_out (cleared only by reset), valid_out = 0.
  - Otherwise valid_out = 0. Other outputs hold their last value.
- A push and a pop in the same cycle keep outstanding unchanged. A pop frees a slot usable on the next cycle, not the same cycle.
- busy_out = state != IDLE.
- Reset mid-frame: sweep aborted, FIFO flushed. Later stray results set orphan_err_out.
- Per frame, exactly WIDTH*HEIGHT valid_out pulses in raster order, given a conforming shader.

Decomposition:
- Shared package render_pkg:
  - RENDER_WIDTH / RENDER_HEIGHT constants (shared with the framebuffer writer).
  - seq_state_t enum {IDLE, SWEEP, DRAIN}.
  - Colour-quantise function.
- Sub-module coord_tag_fifo:
  - Parameterised depth; 21-bit entries.
  - push/pop/full/empty/count; registered pointers.
  - Same-cycle push+pop supported.

Test Plan:
- WIDTH=4, HEIGHT=2; ready always 1; shader returns 3 cycles after accept -> 8 outputs in order (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1); frame_done_out pulses with (3,1); busy_out falls the next cycle.
- Shader never returns, ready=1 -> exactly 16 requests issued, then req_valid_out=0; one res_valid_in -> exactly one more request.
- Colour inputs r=0x07, g=0x08, b=0xFF with hit=1 -> r_out=0, g_out=1, b_out=15. The same inputs with hit=0 -> 0,0,0 and visible_out=0.
- req_ready_in toggled 1,0,0,1 -> req_x/req_y hold during the low cycles; no coordinate is skipped or duplicated.
- res_valid_in pulse in IDLE -> valid_out stays 0 and orphan_err_out=1 until rst_in.
- rst_in asserted mid-SWEEP at (2,1) -> all outputs 0 immediately; a new frame_start_in restarts at (0,0).
